// File: rtl/pe_hazard_pkg.sv
// Purpose: shared definitions for the PE issue/hazard controller.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package pe_hazard_pkg;

    localparam int DEF_RF_INDEX_WIDTH = 5;
    localparam int DEF_NUM_REGS       = 32;
    localparam int DEF_LOAD_LATENCY   = 2;
    localparam int DEF_MUL_LATENCY    = 2;
    localparam int DEF_CNT_WIDTH      = 2;

    // Registers 0 and 1 are hardwired/special and never tracked.
    localparam int SPECIAL_MAX = 1;

    typedef enum logic [1:0] {
        BP_SEL_RF = 2'b00,
        BP_SEL_EX = 2'b01,
        BP_SEL_WB = 2'b10
    } bp_sel_e;

    function automatic logic is_tracked(input logic [31:0] idx);
        return idx > 32'(SPECIAL_MAX);
    endfunction

endpackage

// File: rtl/pe_scoreboard.sv
// Purpose: per-register countdown of cycles until a pending write can be bypassed.
//          Ports: one issue-write port (wr_en_i/wr_addr_i/wr_cnt_i), two busy lookups (A/B).
// Latency: lookups are combinational on pre-update counters; writes land on the next edge.
// Backpressure: none; the caller decides when to write.
module pe_scoreboard
    import pe_hazard_pkg::*;
#(
    parameter int RF_INDEX_WIDTH = DEF_RF_INDEX_WIDTH,
    parameter int NUM_REGS       = DEF_NUM_REGS,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      wr_en_i,
    input  logic [RF_INDEX_WIDTH-1:0] wr_addr_i,
    input  logic [CNT_WIDTH-1:0]      wr_cnt_i,
    input  logic [RF_INDEX_WIDTH-1:0] rd_addr_a_i,
    input  logic [RF_INDEX_WIDTH-1:0] rd_addr_b_i,
    output logic                      busy_a_o,
    output logic                      busy_b_o
);

    logic [CNT_WIDTH-1:0] cnt_q [NUM_REGS];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_REGS];

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            // A fresh issue overrides the countdown of the same register.
            if (wr_en_i && (wr_addr_i == RF_INDEX_WIDTH'(r)) && (r > SPECIAL_MAX)) begin
                cnt_d[r] = wr_cnt_i;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (rst_i) begin
                cnt_q[r] <= '0;
            end else begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign busy_a_o = (cnt_q[rd_addr_a_i] != '0);
    assign busy_b_o = (cnt_q[rd_addr_b_i] != '0);

endmodule

// File: rtl/pe_hazard_ctrl.sv
// Purpose: per-PE issue controller; stalls IF on load-use/multi-cycle hazards and
//          registers bypass selects (RF/EX/WB) for operands A and B into ID.
//          Ports: IF decode fields in, oIF_Stall (comb), oID_Issue/oBP_Sel_A/oBP_Sel_B (registered).
// Latency: stall is combinational; issue and selects appear one cycle after IF.
// Backpressure: oIF_Stall holds IF/PC while a source is pending; flush overrides stall.
module pe_hazard_ctrl
    import pe_hazard_pkg::*;
#(
    parameter int RF_INDEX_WIDTH = DEF_RF_INDEX_WIDTH,
    parameter int NUM_REGS       = DEF_NUM_REGS,
    parameter int LOAD_LATENCY   = DEF_LOAD_LATENCY,
    parameter int MUL_LATENCY    = DEF_MUL_LATENCY,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
    input  logic                      iClk,
    input  logic                      iReset,
    input  logic                      iIF_Valid,
    input  logic [RF_INDEX_WIDTH-1:0] iIF_RF_Read_Addr_A,
    input  logic [RF_INDEX_WIDTH-1:0] iIF_RF_Read_Addr_B,
    input  logic                      iIF_Read_En_A,
    input  logic                      iIF_Read_En_B,
    input  logic [RF_INDEX_WIDTH-1:0] iIF_RF_Write_Addr,
    input  logic                      iIF_RF_Write_Enable,
    input  logic                      iIF_Is_Load,
    input  logic                      iIF_Is_Mul,
    input  logic                      iFlush,
    output logic                      oIF_Stall,
    output logic                      oID_Issue,
    output logic [1:0]                oBP_Sel_A,
    output logic [1:0]                oBP_Sel_B
);

    logic busy_a, busy_b, hz_a, hz_b, issue, sb_wr_en;
    logic [CNT_WIDTH-1:0] sb_wr_cnt;

    // Tracking pipeline: ex_* becomes the EX stage next cycle, wb_* the WB stage.
    logic [RF_INDEX_WIDTH-1:0] ex_wr_q, ex_wr_d, wb_wr_q, wb_wr_d;
    logic ex_vld_q, ex_vld_d, wb_vld_q, wb_vld_d;
    logic ex_rdy_q, ex_rdy_d, wb_mul_q, wb_mul_d, ex_mul_q, ex_mul_d;
    bp_sel_e sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic issue_q, issue_d;

    pe_scoreboard #(
        .RF_INDEX_WIDTH(RF_INDEX_WIDTH),
        .NUM_REGS      (NUM_REGS),
        .CNT_WIDTH     (CNT_WIDTH)
    ) u_sb (
        .clk_i      (iClk),
        .rst_i      (iReset),
        .wr_en_i    (sb_wr_en),
        .wr_addr_i  (iIF_RF_Write_Addr),
        .wr_cnt_i   (sb_wr_cnt),
        .rd_addr_a_i(iIF_RF_Read_Addr_A),
        .rd_addr_b_i(iIF_RF_Read_Addr_B),
        .busy_a_o   (busy_a),
        .busy_b_o   (busy_b)
    );

    assign hz_a      = iIF_Read_En_A & is_tracked(32'(iIF_RF_Read_Addr_A)) & busy_a;
    assign hz_b      = iIF_Read_En_B & is_tracked(32'(iIF_RF_Read_Addr_B)) & busy_b;
    assign oIF_Stall = iIF_Valid & ~iFlush & (hz_a | hz_b);
    assign issue     = iIF_Valid & ~iFlush & ~oIF_Stall;
    assign sb_wr_en  = issue & iIF_RF_Write_Enable & is_tracked(32'(iIF_RF_Write_Addr));

    always_comb begin
        sb_wr_cnt = '0;
        if (iIF_Is_Load) begin
            sb_wr_cnt = CNT_WIDTH'(LOAD_LATENCY - 1);
        end else if (iIF_Is_Mul) begin
            sb_wr_cnt = CNT_WIDTH'(MUL_LATENCY - 1);
        end
    end

    // Youngest match wins. A multiply result surfaces on the EX bypass path,
    // so a multiply found in the WB slot still selects EX data.
    function automatic bp_sel_e sel_for(
        input logic                      en,
        input logic [RF_INDEX_WIDTH-1:0] addr,
        input logic                      exv,
        input logic                      exr,
        input logic [RF_INDEX_WIDTH-1:0] exa,
        input logic                      wbv,
        input logic                      wbm,
        input logic [RF_INDEX_WIDTH-1:0] wba
    );
        bp_sel_e s;
        s = BP_SEL_RF;
        if (en && is_tracked(32'(addr))) begin
            if (exv && exr && (exa == addr)) begin
                s = BP_SEL_EX;
            end else if (wbv && (wba == addr)) begin
                s = wbm ? BP_SEL_EX : BP_SEL_WB;
            end
        end
        return s;
    endfunction

    always_comb begin
        issue_d  = issue;
        ex_wr_d  = iIF_RF_Write_Addr;
        ex_vld_d = sb_wr_en;
        ex_rdy_d = ~iIF_Is_Load & ~iIF_Is_Mul;
        ex_mul_d = iIF_Is_Mul & ~iIF_Is_Load;
        wb_wr_d  = ex_wr_q;
        wb_vld_d = ex_vld_q;
        wb_mul_d = ex_mul_q;
        sel_a_d  = BP_SEL_RF;
        sel_b_d  = BP_SEL_RF;
        if (issue) begin
            sel_a_d = sel_for(iIF_Read_En_A, iIF_RF_Read_Addr_A, ex_vld_q, ex_rdy_q,
                              ex_wr_q, wb_vld_q, wb_mul_q, wb_wr_q);
            sel_b_d = sel_for(iIF_Read_En_B, iIF_RF_Read_Addr_B, ex_vld_q, ex_rdy_q,
                              ex_wr_q, wb_vld_q, wb_mul_q, wb_wr_q);
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            issue_q  <= 1'b0;
            ex_wr_q  <= '0;
            ex_vld_q <= 1'b0;
            ex_rdy_q <= 1'b0;
            ex_mul_q <= 1'b0;
            wb_wr_q  <= '0;
            wb_vld_q <= 1'b0;
            wb_mul_q <= 1'b0;
            sel_a_q  <= BP_SEL_RF;
            sel_b_q  <= BP_SEL_RF;
        end else begin
            issue_q  <= issue_d;
            ex_wr_q  <= ex_wr_d;
            ex_vld_q <= ex_vld_d;
            ex_rdy_q <= ex_rdy_d;
            ex_mul_q <= ex_mul_d;
            wb_wr_q  <= wb_wr_d;
            wb_vld_q <= wb_vld_d;
            wb_mul_q <= wb_mul_d;
            sel_a_q  <= sel_a_d;
            sel_b_q  <= sel_b_d;
        end
    end

    assign oID_Issue = issue_q;
    assign oBP_Sel_A = sel_a_q;
    assign oBP_Sel_B = sel_b_q;

endmodule

// File: doc/pe_hazard_ctrl.md
Name: pe_hazard_ctrl

Overview:
- Per-PE issue controller in front of the operand bypass network.
- Tracks in-flight register writes in a small scoreboard and stalls IF on load-use and multi-cycle hazards.
- Produces registered bypass-select codes (RF / EX / WB) for operands A and B, so the ID-stage operand muxes no longer need address comparators on the critical path.
- One instance per PE; sits between instruction decode (IF) and the bypass/operand muxes (ID).

Parameters:
- RF_INDEX_WIDTH, 5, register index width.
- NUM_REGS, 32, architectural registers tracked.
- LOAD_LATENCY, 2, cycles from issue until load data is available on the WB bypass path.
- MUL_LATENCY, 2, cycles from issue until multiply result is available on the EX bypass path.
- CNT_WIDTH, 2, scoreboard counter width; must hold max(LOAD_LATENCY, MUL_LATENCY).

Ports:
- iClk  in  1  clock
- iReset  in  1  synchronous reset, active-high
- iIF_Valid  in  1  decoded instruction present in IF
- iIF_RF_Read_Addr_A  in  RF_INDEX_WIDTH  source A index
- iIF_RF_Read_Addr_B  in  RF_INDEX_WIDTH  source B index
- iIF_Read_En_A  in  1  instruction actually reads A (0 for neighbour/CP operand)
- iIF_Read_En_B  in  1  instruction reads B (0 if immediate selected and not a store)
- iIF_RF_Write_Addr  in  RF_INDEX_WIDTH  destination index
- iIF_RF_Write_Enable  in  1  instruction writes RF
- iIF_Is_Load  in  1  destination produced by LSU
- iIF_Is_Mul  in  1  destination produced by multiplier
- iFlush  in  1  kill IF instruction this cycle
- oIF_Stall  out  1  hold IF/PC; ID receives a bubble
- oID_Issue  out  1  registered: ID holds a valid issued instruction
- oBP_Sel_A  out  2  registered: 00 RF, 01 EX data, 10 WB data
- oBP_Sel_B  out  2  same encoding for operand B / store data

Behaviour:
- Reset (sync, iReset=1 at posedge): all scoreboard counters=0, EX/WB dest tracking invalid. oID_Issue=0, oBP_Sel_A=oBP_Sel_B=00. oIF_Stall is combinational, therefore 0 immediately after reset.
- Reset mid-operation discards every pending counter; no stall survives reset.
- Tracking: indices 0 and 1 are hardwired/special. They are never tracked, never stall, and always select 00.
- Scoreboard: per register r (2..NUM_REGS-1), cnt[r] = remaining cycles until the value can be bypassed.
  - Decrements by 1 each cycle when non-zero; saturates at 0.
- Hazard (combinational): hzA = iIF_Read_En_A & addrA>1 & cnt[addrA]!=0; hzB likewise.
- oIF_Stall = iIF_Valid & ~iFlush & (hzA | hzB).
- issue = iIF_Valid & ~iFlush & ~oIF_Stall.
- On issue with write enable and wrAddr>1:
  - cnt[wr] <= LOAD_LATENCY-1 if load;
  - MUL_LATENCY-1 if mul;
  - 0 otherwise (ALU, EX bypass next cycle).
  - The issue write has priority over that register's decrement in the same cycle.
- Hazard checks use pre-update counters. An instruction reading and writing the same register checks the old value.
- Pipeline tracking shift registers, advanced every cycle; a bubble shifts in invalid:
  - EXd <= (wr, valid, ready-at-EX);
  - WBd <= EXd.
  - For load/mul, the dest is marked valid in the stage where data actually appears.
- Select (registered into ID on the same edge as issue), computed from the IF addresses against the stage contents that will be EX/WB next cycle:
  - EX match has priority over WB match;
  - no match gives 00.
  - When not issuing, oBP_Sel_* <= 00 and oID_Issue <= 0.
- Stall latency: one stall cycle per remaining count. A load followed immediately by a consumer stalls LOAD_LATENCY-1 cycles (1 at default).
- Flush: the IF instruction is dropped (no issue, no scoreboard write, bubble into ID). In-flight counters keep counting down.
- Flush and stall in the same cycle: flush wins, oIF_Stall=0.
- Back-to-back writes to the same register: the latest issue overwrites cnt and the bypass tracking. A younger ALU write masks an older pending load.

Decomposition:
- Shared package (def-pe include): bypass select encodings BP_SEL_RF/EX/WB, RF_INDEX_WIDTH, special-register bound (index<=1), latency defaults.
- One natural sub-module: pe_scoreboard (counter array with issue-write/decrement/lookup on two read ports).
- Stall logic, tracking pipeline and select generation stay in pe_hazard_ctrl.

Test Plan:
- ALU r5 issued, next cycle ADD reads r5 as A -> no stall, oBP_Sel_A=01, oID_Issue=1.
- LOAD r7, next instr reads r7 as B -> oIF_Stall=1 for 1 cycle, then issue with oBP_Sel_B=10 (LOAD_LATENCY=2).
- MUL r3; ALU r3; read r3 -> ALU overwrites, no stall on read, oBP_Sel=01 from ALU result.
- Read r0/r1 while LOAD r1 pending -> never stalls, sel=00.
- LOAD r9 then iFlush on dependent instr with hazard -> oIF_Stall=0, oID_Issue=0 next cycle, cnt[r9] still decrements to 0.
- LOAD r4, assert iReset next cycle, then read r4 -> no stall, sel=00, all outputs at reset values.
